wide_add_seq: RTL and testbench

WIDE_ADD_SEQ -- requirements
Module: wide_add_seq

---
 rtl/wide_add_seq.sv | 118 +++++++++++
 tb/tb_wide_add_seq.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/wide_add_seq.sv
// Nibble-serial adder: one 4-bit ripple slice is reused across NIBBLES cycles, LSB nibble first.
// Valid/ready on both sides. A result stays held in DONE until the consumer takes it.

module wide_add_seq_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);
  logic [3:0] p, g;
  logic [4:0] c;

  assign c[0] = cin;
  for (genvar k = 0; k < 4; k++) begin : g_bit
    assign p[k]   = a[k] ^ b[k];
    assign g[k]   = a[k] & b[k];
    assign s[k]   = p[k] ^ c[k];
    assign c[k+1] = g[k] | (c[k] & p[k]);
  end
  assign cout = c[4];
endmodule

module wide_add_seq #(
  parameter  int NIBBLES = 4,
  localparam int W       = 4 * NIBBLES,
  localparam int IW      = $clog2(NIBBLES + 1)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         io_in_valid,
  output logic         io_in_ready,
  input  logic [W-1:0] io_in_a,
  input  logic [W-1:0] io_in_b,
  input  logic         io_in_cin,
  output logic         io_out_valid,
  input  logic         io_out_ready,
  output logic [W-1:0] io_out_sum,
  output logic         io_out_cout
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state, nstate;
  logic [W-1:0]   a_r, b_r, sum_r;
  logic           carry;
  logic [IW-1:0]  idx;
  logic [3:0]     a_nib, b_nib, s_nib;
  logic           c_nib;
  logic           accept, last;

  assign accept = io_in_valid && (state == IDLE);
  assign last   = (idx == IW'(NIBBLES - 1));

  // Nibble mux driven by the index; a compare per slot keeps widths exact.
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx == IW'(i)) begin
        a_nib = a_r[i*4 +: 4];
        b_nib = b_r[i*4 +: 4];
      end
    end
  end

  wide_add_seq_slice u_slice (
    .a   (a_nib),
    .b   (b_nib),
    .cin (carry),
    .s   (s_nib),
    .cout(c_nib)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (accept)       nstate = RUN;
      RUN:     if (last)         nstate = DONE;
      DONE:    if (io_out_ready) nstate = IDLE;
      default:                   nstate = IDLE;
    endcase
  end

  always_comb begin
    io_in_ready  = (state == IDLE);
    io_out_valid = (state == DONE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      a_r   <= '0;
      b_r   <= '0;
      sum_r <= '0;
      carry <= 1'b0;
      idx   <= '0;
    end else if (accept) begin
      a_r   <= io_in_a;
      b_r   <= io_in_b;
      sum_r <= '0;
      carry <= io_in_cin;
      idx   <= '0;
    end else if (state == RUN) begin
      for (int i = 0; i < NIBBLES; i++)
        if (idx == IW'(i)) sum_r[i*4 +: 4] <= s_nib;
      carry <= c_nib;
      idx   <= idx + IW'(1);
    end
  end

  // Carry is the final carry once DONE is reached and holds through IDLE.
  assign io_out_sum  = sum_r;
  assign io_out_cout = carry;
endmodule

// File: tb/tb_wide_add_seq.sv
// Randomized bench for wide_add_seq: an arithmetic/timing model checks every cycle,
// directed cases pin the model with hand-computed sums.

module tb_wide_add_seq;
  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clock, reset;
  logic         in_valid, in_ready, in_cin, out_valid, out_ready, out_cout;
  logic [W-1:0] in_a, in_b, out_sum;

  logic         v1, rdy1, cin1, ov1, r1, co1;
  logic [3:0]   a1, b1, s1;

  int vectors = 0;
  int miscompares = 0;

  wide_add_seq #(.NIBBLES(N)) dut (
    .clock(clock), .reset(reset),
    .io_in_valid(in_valid), .io_in_ready(in_ready),
    .io_in_a(in_a), .io_in_b(in_b), .io_in_cin(in_cin),
    .io_out_valid(out_valid), .io_out_ready(out_ready),
    .io_out_sum(out_sum), .io_out_cout(out_cout)
  );

  wide_add_seq #(.NIBBLES(1)) dut1 (
    .clock(clock), .reset(reset),
    .io_in_valid(v1), .io_in_ready(rdy1),
    .io_in_a(a1), .io_in_b(b1), .io_in_cin(cin1),
    .io_out_valid(ov1), .io_out_ready(r1),
    .io_out_sum(s1), .io_out_cout(co1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  // Model: an op is busy from accept; result is presented N edges later and
  // leaves on the first edge with out_ready high. Sum is plain integer addition.
  logic         m_busy;
  int           m_cnt, cyc, prev_acc;
  bit           have_prev, b2b;
  logic [W-1:0] exp_sum, m_hold_sum;
  logic         exp_cout, m_hold_cout;

  initial begin
    m_busy = 0; m_cnt = 0; cyc = 0; prev_acc = 0; have_prev = 0;
    exp_sum = '0; exp_cout = 0; m_hold_sum = '0; m_hold_cout = 0;
  end

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_busy = 0; m_cnt = 0; m_hold_sum = '0; m_hold_cout = 0; have_prev = 0;
    end else begin
      cyc++;
      if (!m_busy) begin
        if (in_valid) begin
          {exp_cout, exp_sum} = (W+1)'(in_a) + (W+1)'(in_b) + (W+1)'(in_cin);
          m_busy = 1; m_cnt = 0;
          if (b2b) begin
            if (have_prev) chk("accept_spacing", cyc - prev_acc, N + 2);
            prev_acc = cyc; have_prev = 1;
          end else have_prev = 0;
        end
      end else if (m_cnt < N) m_cnt++;
      else if (out_ready) begin
        m_busy = 0; m_hold_sum = exp_sum; m_hold_cout = exp_cout;
      end
    end
  end

  always @(negedge clock) begin
    chk("in_ready", in_ready, !m_busy);
    chk("out_valid", out_valid, m_busy && m_cnt == N);
    if (m_busy && m_cnt == N) begin
      chk("sum", out_sum, exp_sum);
      chk("cout", out_cout, exp_cout);
    end else if (!m_busy) begin
      chk("idle_sum", out_sum, m_hold_sum);
      chk("idle_cout", out_cout, m_hold_cout);
    end
  end

  // Present one operand set, let it be accepted, then scramble the inputs and
  // wait (bounded) for out_valid. Returns the edge count from accept.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       output int lat);
    in_a = a; in_b = b; in_cin = c; in_valid = 1;
    @(posedge clock); #1;
    in_valid = 0; in_a = W'($urandom); in_b = W'($urandom); in_cin = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      chk("busy_ready_low", in_ready, 1'b0);
      @(posedge clock); #1;
      lat++;
    end
    if (!out_valid) chk("out_valid_timeout", out_valid, 1'b1);
  endtask

  initial begin
    int lat;
    logic [W-1:0] s0;
    logic c0;
    reset = 0; in_valid = 0; in_a = '0; in_b = '0; in_cin = 0; out_ready = 1; b2b = 0;
    v1 = 0; a1 = '0; b1 = '0; cin1 = 0; r1 = 1;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_ready", in_ready, 1'b1);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_sum", out_sum, 16'h0000);
    chk("rst_cout", out_cout, 1'b0);
    reset = 1;

    issue(16'hFFFF, 16'h0001, 1'b0, lat);
    chk("lat_ffff", lat, N);
    chk("sum_ffff", out_sum, 16'h0000);
    chk("cout_ffff", out_cout, 1'b1);
    chk("model_pin_ffff", {exp_cout, exp_sum}, 17'h10000);
    @(posedge clock); #1;
    chk("hs_valid_low", out_valid, 1'b0);
    chk("hs_sum_held", out_sum, 16'h0000);

    issue(16'h1234, 16'h4321, 1'b1, lat);
    chk("sum_1234", out_sum, 16'h5556);
    chk("cout_1234", out_cout, 1'b0);
    chk("model_pin_1234", {exp_cout, exp_sum}, 17'h05556);
    @(posedge clock); #1;

    out_ready = 0;
    issue(W'($urandom), W'($urandom), 1'($urandom), lat);
    s0 = out_sum; c0 = out_cout;
    repeat (5) begin
      in_valid = 1'($urandom); in_a = W'($urandom); in_b = W'($urandom);
      @(posedge clock); #1;
      chk("bp_valid", out_valid, 1'b1);
      chk("bp_sum", out_sum, s0);
      chk("bp_cout", out_cout, c0);
    end
    in_valid = 0; out_ready = 1;
    @(posedge clock); #1;
    chk("bp_release", out_valid, 1'b0);

    in_a = 16'hAAAA; in_b = 16'h5555; in_cin = 0; in_valid = 1;
    @(posedge clock); #1;
    in_valid = 0;
    @(posedge clock); #1;
    #2 reset = 0;
    #1;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_sum", out_sum, 16'h0000);
    chk("mid_rst_cout", out_cout, 1'b0);
    chk("mid_rst_ready", in_ready, 1'b1);
    repeat (2) @(posedge clock);
    #1 reset = 1;
    issue(16'h0F0F, 16'h00F1, 1'b0, lat);
    chk("lat_after_rst", lat, N);
    chk("sum_0f0f", out_sum, 16'h1000);
    chk("cout_0f0f", out_cout, 1'b0);
    @(posedge clock); #1;

    repeat (8) begin
      issue(W'($urandom), W'($urandom), 1'($urandom), lat);
      chk("lat_rand", lat, N);
      @(posedge clock); #1;
    end

    b2b = 1; in_valid = 1; out_ready = 1;
    repeat (60) begin
      in_a = W'($urandom); in_b = W'($urandom); in_cin = 1'($urandom);
      @(posedge clock); #1;
    end
    in_valid = 0;
    repeat (N + 3) @(posedge clock);
    #1 b2b = 0;

    a1 = 4'hF; b1 = 4'h1; cin1 = 1; v1 = 1;
    @(posedge clock); #1;
    v1 = 0;
    chk("n1_not_yet", ov1, 1'b0);
    @(posedge clock); #1;
    chk("n1_valid", ov1, 1'b1);
    chk("n1_sum", s1, 4'h1);
    chk("n1_cout", co1, 1'b1);

    repeat (3) @(posedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
